// File: rtl/gray_count_sched_if.sv
// Requester-side bus of the shared counter scheduler: per-requester commands in,
// grant/done/count back out.
interface gray_count_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 3
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]            req;
  logic [NREQ-1:0][1:0]       cmd;
  logic [NREQ-1:0][WIDTH-1:0] ld_val;
  logic [NREQ-1:0]            gnt;
  logic [IDW-1:0]             gnt_id;
  logic                       busy;
  logic                       done;
  logic [WIDTH-1:0]           count;
  logic [WIDTH-1:0]           gray;

  modport master (
    output req, cmd, ld_val,
    input  gnt, gnt_id, busy, done, count, gray
  );

  modport slave (
    input  req, cmd, ld_val,
    output gnt, gnt_id, busy, done, count, gray
  );
endinterface

// File: rtl/gray_count_sched.sv
// Round-robin scheduler sharing one bounded up/down/load counter between NREQ
// requesters; one transaction every three cycles, count published as binary and Gray.
module gray_count_sched #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 3,
  parameter int MAXVAL = 4
) (
  input  logic             clk,
  input  logic             reset,
  gray_count_sched_if.slave bus
);
  localparam int               IDW  = $clog2(NREQ);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAXVAL);

  typedef enum logic [1:0] {IDLE, GRANT, EXEC} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] ldv_q, ldv_d;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [WIDTH-1:0] result;
  int               j;

  // Search starts one past the last winner and wraps, so the last winner ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(last_q) + 1 + k) % NREQ;
      if (!win_found && bus.req[j]) begin
        win_found = 1'b1;
        win_id    = IDW'(j);
      end
    end
  end

  always_comb begin
    result = count_q;
    case (cmd_q)
      2'b01:   result = (count_q == MAXV) ? '0 : count_q + 1'b1;
      2'b10:   result = (count_q == '0) ? MAXV : count_q - 1'b1;
      2'b11:   result = (ldv_q > MAXV) ? MAXV : ldv_q;
      default: result = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_id_d = gnt_id_q;
    gnt_d    = '0;
    done_d   = 1'b0;
    count_d  = count_q;
    cmd_d    = cmd_q;
    ldv_d    = ldv_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = GRANT;
          last_d   = win_id;
          gnt_id_d = win_id;
          gnt_d    = NREQ'(1) << win_id;
          cmd_d    = bus.cmd[win_id];
          ldv_d    = bus.ld_val[win_id];
        end
      end
      GRANT: begin
        count_d = result;
        done_d  = 1'b1;
        state_d = EXEC;
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset drops any captured command; nothing in flight survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_q   <= IDW'(NREQ - 1);
      gnt_id_q <= '0;
      gnt_q    <= '0;
      done_q   <= 1'b0;
      count_q  <= '0;
      cmd_q    <= '0;
      ldv_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_id_q <= gnt_id_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      count_q  <= count_d;
      cmd_q    <= cmd_d;
      ldv_q    <= ldv_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.count  = count_q;
  assign bus.gray   = count_q ^ (count_q >> 1);
endmodule

// File: tb/tb_gray_count_sched.sv
// Scoreboard bench for gray_count_sched: expected {winner, count} pushed on stimulus,
// popped and compared on every done pulse.
module tb_gray_count_sched;
  localparam int NREQ   = 4;
  localparam int WIDTH  = 3;
  localparam int MAXVAL = 4;

  logic clk = 1'b0;
  logic reset;

  gray_count_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  gray_count_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXVAL(MAXVAL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int cnt; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model(input int c, input int op, input int ld);
    case (op)
      1:       return (c == MAXVAL) ? 0 : c + 1;
      2:       return (c == 0) ? MAXVAL : c - 1;
      3:       return (ld > MAXVAL) ? MAXVAL : ld;
      default: return c;
    endcase
  endfunction

  function automatic int gray_of(input int c);
    return c ^ (c >> 1);
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("done_id",   bus.gnt_id, mon_e.id);
        chk("done_cnt",  bus.count,  mon_e.cnt);
        chk("done_gray", bus.gray,   gray_of(mon_e.cnt));
      end
    end
  end

  task automatic drive(input int id, input int op, input int ld);
    logic [31:0] o, l;
    o = op;
    l = ld;
    bus.req[id]    = 1'b1;
    bus.cmd[id]    = o[1:0];
    bus.ld_val[id] = l[WIDTH-1:0];
    exp_cnt = model(exp_cnt, op, ld);
    sb.push_back('{id, exp_cnt});
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the FSM is back in IDLE.
  task automatic txn(input int id, input int op, input int ld);
    drive(id, op, ld);
    @(negedge clk);
    chk("gnt",    bus.gnt, 1 << id);
    chk("busy_g", bus.busy, 1);
    chk("done_g", bus.done, 0);
    bus.req[id] = 1'b0;
    @(negedge clk);
    chk("done_x", bus.done, 1);
    chk("busy_x", bus.busy, 1);
    chk("gnt_x",  bus.gnt, 0);
    @(negedge clk);
    chk("idle",     bus.busy, 0);
    chk("done_off", bus.done, 0);
  endtask

  task automatic wait_gnt(input int exp_id, output time t);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.gnt == '0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    t = $time;
    if (w == 10) chk("gnt_timeout", 0, 1);
    else begin
      chk("rr_id",  bus.gnt_id, exp_id);
      chk("rr_gnt", bus.gnt, 1 << exp_id);
    end
    bus.req[exp_id] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    time t0, t1;
    reset      = 1'b0;
    bus.req    = '0;
    bus.cmd    = '0;
    bus.ld_val = '0;
    #1;
    chk("rst_gnt",    bus.gnt, 0);
    chk("rst_gnt_id", bus.gnt_id, 0);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_done",   bus.done, 0);
    chk("rst_count",  bus.count, 0);
    chk("rst_gray",   bus.gray, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_busy",  bus.busy, 0);
      chk("idle_gnt",   bus.gnt, 0);
      chk("idle_count", bus.count, 0);
    end

    txn(0, 1, 0);  // step up 0->1
    txn(1, 3, 4);  // load 4
    txn(2, 1, 0);  // wrap up 4->0
    txn(3, 2, 0);  // wrap down 0->4
    txn(0, 3, 7);  // clamp to 4
    txn(1, 3, 2);  // load 2
    txn(2, 0, 0);  // hold

    // Fresh reset so requester 0 has first priority again.
    reset = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    exp_cnt = 0;
    @(negedge clk);

    for (int i = 0; i < NREQ; i++) drive(i, 1, 0);
    for (int k = 0; k < NREQ; k++) begin
      wait_gnt(k, t1);
      if (k > 0) chk("rr_spacing", 32'(t1 - t0), 30);
      t0 = t1;
    end
    repeat (2) @(negedge clk);
    chk("rr_idle", bus.busy, 0);

    txn(2, 0, 0);
    drive(0, 1, 0);
    drive(2, 2, 0);
    wait_gnt(0, t0);
    wait_gnt(2, t1);
    chk("resume_spacing", 32'(t1 - t0), 30);
    repeat (2) @(negedge clk);
    chk("resume_idle", bus.busy, 0);

    // Abort: reset lands while the up command is granted but not yet executed.
    txn(1, 3, 3);
    bus.req[1] = 1'b1;
    bus.cmd[1] = 2'b01;
    @(negedge clk);
    chk("abort_gnt", bus.gnt, 4'b0010);
    reset = 1'b0;
    #1;
    chk("abort_count", bus.count, 0);
    chk("abort_gray",  bus.gray, 0);
    chk("abort_gnt0",  bus.gnt, 0);
    chk("abort_busy",  bus.busy, 0);
    bus.req = '0;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    chk("abort_done", bus.done, 0);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_busy",  bus.busy, 0);
      chk("post_done",  bus.done, 0);
      chk("post_count", bus.count, 0);
    end
    txn(0, 1, 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
